fc_accumulator: RTL and testbench

Sequential reduction stage that sits directly behind the FC1 multiplier array. Each cycle the array presents NUMBER_OF_WM single-precision products, one per output neuron, for one input feature. This block accumulates those products over IFM_DEPTH beats into one IEEE-754 running sum per lane. It then presents the completed dot products to the next layer through a valid/ready handshake.

---
 rtl/fc_accumulator.sv | 170 +++++++++++++++++
 tb/tb_fc_accumulator.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fc_accumulator.sv
// FC1 reduction stage: per-lane IEEE-754 running sums over IFM_DEPTH beats,
// emitted as one packed vector through a valid/ready handshake.

module fp_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  logic        swap;
  logic [31:0] big, sml;
  logic [7:0]  eb, es, ebe, ese, d;
  logic [4:0]  dcap, lz;
  logic [23:0] mb, ms;
  logic [53:0] wide;
  logic [26:0] bm, sm, n;
  logic [27:0] sum;
  logic [9:0]  e, lim, sh, ef;
  logic        rup;
  logic [24:0] r;
  logic [22:0] frac;

  always_comb begin
    swap = a[30:0] < b[30:0];
    big  = swap ? b : a;
    sml  = swap ? a : b;
    eb   = big[30:23];
    es   = sml[30:23];
    mb   = {|eb, big[22:0]};
    ms   = {|es, sml[22:0]};
    ebe  = (eb == 8'd0) ? 8'd1 : eb;
    ese  = (es == 8'd0) ? 8'd1 : es;
    d    = ebe - ese;
    dcap = (d > 8'd27) ? 5'd27 : d[4:0];
    // wide keeps every shifted-out bit so sticky stays exact
    wide = {ms, 30'b0} >> dcap;
    sm   = {wide[53:28], |wide[27:0]};
    bm   = {mb, 3'b0};
    e    = {2'b0, ebe};
    sum  = '0;
    lz   = 5'd27;
    lim  = '0;
    sh   = '0;
    if (big[31] == sml[31]) begin
      sum = {1'b0, bm} + {1'b0, sm};
      if (sum[27]) begin
        n = {sum[27:2], |sum[1:0]};
        e = e + 10'd1;
      end else begin
        n = sum[26:0];
      end
    end else begin
      n = bm - sm;
      for (int i = 0; i < 27; i++)
        if (n[i]) lz = 5'(26 - i);
      lim = e - 10'd1;
      sh  = ({5'b0, lz} < lim) ? {5'b0, lz} : lim;
      n   = n << sh;
      e   = e - sh;
    end
    rup = n[2] & (n[1] | n[0] | n[3]);
    r   = {1'b0, n[26:3]} + {24'b0, rup};
    if (r[24]) begin
      ef   = e + 10'd1;
      frac = r[23:1];
    end else begin
      ef   = r[23] ? e : 10'd0;
      frac = r[22:0];
    end
    if (ef >= 10'd255)
      y = {big[31], 8'hff, 23'b0};
    else
      y = {big[31], ef[7:0], frac};
    if (n == 27'd0)
      y = '0;
    if (eb == 8'hff) begin
      if (es == 8'hff && big[31] != sml[31])
        y = 32'h7fc00000;
      else
        y = big;
    end
  end

endmodule

module fc_accumulator #(
  parameter int DATA_WIDTH   = 32,
  parameter int IFM_DEPTH    = 120,
  parameter int NUMBER_OF_WM = 84,
  parameter int COUNT_W      = $clog2(IFM_DEPTH)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               clear,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [NUMBER_OF_WM*DATA_WIDTH-1:0] in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [NUMBER_OF_WM*DATA_WIDTH-1:0] out_data,
  output logic [COUNT_W-1:0]                 beat_count
);

  typedef enum logic {S_ACC, S_OUT} state_t;

  state_t state, state_nx;
  logic   accept, first, last;

  assign accept = in_valid & in_ready;
  assign first  = beat_count == '0;
  assign last   = beat_count == COUNT_W'(IFM_DEPTH - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_ACC;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      clear:                   state_nx = S_ACC;
      state == S_ACC && accept && last:
                               state_nx = S_OUT;
      state == S_OUT && out_ready:
                               state_nx = S_ACC;
      default:                 state_nx = state;
    endcase
  end

  always_comb begin
    in_ready  = state == S_ACC;
    out_valid = state == S_OUT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      beat_count <= '0;
    else if (clear)
      beat_count <= '0;
    else if (accept)
      beat_count <= last ? '0 : beat_count + 1'b1;
  end

  for (genvar k = 0; k < NUMBER_OF_WM; k++) begin : g_lane
    logic [DATA_WIDTH-1:0] acc, sum, prod;

    assign prod = in_data[k*DATA_WIDTH +: DATA_WIDTH];

    fp_adder u_add (
      .a (acc),
      .b (prod),
      .y (sum)
    );

    // first beat loads the product so a -0 product is kept as -0
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        acc <= '0;
      else if (clear)
        acc <= '0;
      else if (accept)
        acc <= first ? prod : sum;
    end

    assign out_data[k*DATA_WIDTH +: DATA_WIDTH] = acc;
  end

endmodule

// File: tb/tb_fc_accumulator.sv
// Scoreboard bench for fc_accumulator: expected vectors queued at stimulus,
// checked lane by lane at each output handshake.

module tb_fc_accumulator;

  localparam int DW = 32;
  localparam int DEPTH = 120;
  localparam int NW = 84;
  localparam int CW = $clog2(DEPTH);
  localparam int BW = NW * DW;

  logic          clk, rst_n, clear;
  logic          in_valid, in_ready;
  logic [BW-1:0] in_data;
  logic          out_valid, out_ready;
  logic [BW-1:0] out_data;
  logic [CW-1:0] beat_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [BW-1:0] sb[$];

  fc_accumulator #(
    .DATA_WIDTH   (DW),
    .IFM_DEPTH    (DEPTH),
    .NUMBER_OF_WM (NW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .beat_count (beat_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] int2fp(input int v);
    int m;
    int sh;
    if (v == 0) return 32'h0;
    m = 0;
    for (int i = 0; i < 31; i++)
      if (v[i]) m = i;
    sh = v << (23 - m);
    return {1'b0, 8'(127 + m), sh[22:0]};
  endfunction

  function automatic logic [BW-1:0] fill(input logic [31:0] v);
    logic [BW-1:0] t;
    for (int k = 0; k < NW; k++) t[k*DW +: DW] = v;
    return t;
  endfunction

  function automatic logic [BW-1:0] ramp(input int scale);
    logic [BW-1:0] t;
    for (int k = 0; k < NW; k++) t[k*DW +: DW] = int2fp(k * scale);
    return t;
  endfunction

  function automatic logic [31:0] lane(input logic [BW-1:0] v,
                                       input int k);
    return v[k*DW +: DW];
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", 32'd1, 32'd0);
      end else begin
        logic [BW-1:0] exp;
        exp = sb.pop_front();
        for (int k = 0; k < NW; k++)
          chk($sformatf("lane%0d", k), lane(out_data, k), lane(exp, k));
        chk("bc_at_out", 32'(beat_count), 32'd0);
      end
    end
  end

  // n beats of data; gap inserts an idle cycle before every beat
  task automatic send(input int n, input logic [BW-1:0] data,
                      input bit gap, input bit last_chk);
    for (int i = 0; i < n; i++) begin
      if (gap) begin
        logic [CW-1:0] bc;
        in_valid = 1'b0;
        bc = beat_count;
        @(posedge clk); #1;
        if (i == 5) chk("gap_hold", 32'(beat_count), 32'(bc));
      end
      in_valid = 1'b1;
      in_data  = data;
      if (last_chk && i == n - 1)
        chk("pre_valid", {31'b0, out_valid}, 32'd0);
      @(posedge clk); #1;
      if (gap && i == 5) chk("gap_step", 32'(beat_count), 32'd6);
    end
    in_valid = 1'b0;
    in_data  = '0;
    if (last_chk) begin
      chk("valid_lat", {31'b0, out_valid}, 32'd1);
      chk("rdy_low", {31'b0, in_ready}, 32'd0);
      chk("bc_wrap", 32'(beat_count), 32'd0);
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("valid_fall", {31'b0, out_valid}, 32'd0);
    chk("rdy_back", {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_bc", 32'(beat_count), 32'd0);
    chk("rst_data", lane(out_data, 0), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    sb.push_back(fill(32'h42F00000));
    send(DEPTH, fill(32'h3F800000), 1'b0, 1'b1);
    drain();

    sb.push_back(fill(32'h42700000));
    send(DEPTH, fill(32'h3F000000), 1'b0, 1'b1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("hold_rdy", {31'b0, in_ready}, 32'd0);
      chk("hold_l0", lane(out_data, 0), 32'h42700000);
      chk("hold_l83", lane(out_data, NW - 1), 32'h42700000);
    end
    @(posedge clk); #1;
    drain();

    sb.push_back(ramp(DEPTH));
    send(DEPTH, ramp(1), 1'b0, 1'b1);
    chk("ind_l0", lane(out_data, 0), 32'h00000000);
    chk("ind_l1", lane(out_data, 1), 32'h42F00000);
    drain();

    sb.push_back(fill(32'h42F00000));
    send(DEPTH, fill(32'h3F800000), 1'b1, 1'b1);
    drain();

    send(50, fill(32'h3F800000), 1'b0, 1'b0);
    chk("pre_clr_bc", 32'(beat_count), 32'd50);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = fill(32'h3F800000);
    @(posedge clk); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clr_bc", 32'(beat_count), 32'd0);
    chk("clr_data", lane(out_data, 7), 32'd0);
    sb.push_back(fill(32'h43700000));
    send(DEPTH, fill(32'h40000000), 1'b0, 1'b1);
    drain();

    send(70, fill(32'h3F800000), 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_bc", 32'(beat_count), 32'd0);
    chk("arst_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_ready", {31'b0, in_ready}, 32'd1);
    chk("arst_data", lane(out_data, 3), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    sb.push_back(fill(32'h42F00000));
    send(DEPTH, fill(32'h3F800000), 1'b0, 1'b1);
    drain();

    repeat (2) @(posedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
